// File: rtl/qdr_req_buffer_pkg.sv
// Shared widths and packed request-entry layout for the QDR request buffer.
// Entry layout, MSB to LSB: {addr, wr, rd, data, be}.
package qdr_req_buffer_pkg;

  localparam int QDR_ADDR_WIDTH_D = 21;
  localparam int QDR_DATA_WIDTH_D = 36;
  localparam int QDR_BW_WIDTH_D   = 2;
  localparam int FIFO_AWIDTH_D    = 3;
  localparam int OUTST_WIDTH_D    = 5;

  localparam int BE_LSB = 0;

  function automatic int f_data_lsb(input int bw);
    return 2 * bw;
  endfunction

  function automatic int f_rd_bit(input int dw, input int bw);
    return 2 * bw + 2 * dw;
  endfunction

  function automatic int f_wr_bit(input int dw, input int bw);
    return f_rd_bit(dw, bw) + 1;
  endfunction

  function automatic int f_addr_lsb(input int dw, input int bw);
    return f_rd_bit(dw, bw) + 2;
  endfunction

  function automatic int f_entry_w(input int aw, input int dw, input int bw);
    return f_addr_lsb(dw, bw) + aw;
  endfunction

endpackage

// File: rtl/qdr_req_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on o_dout
// whenever o_empty is low. A push while full is refused even if a pop occurs.
module qdr_req_fifo #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_CNT = DEPTH[AWIDTH:0];

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_CNT);
  assign o_dout  = r_mem[r_rptr];

  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/qdr_req_buffer.sv
// Buffers fabric QDR requests and issues them in order to the sniffer slave port,
// tracking in-flight reads and registering read returns back to the fabric.
module qdr_req_buffer
  import qdr_req_buffer_pkg::*;
#(
  parameter int QDR_ADDR_WIDTH = QDR_ADDR_WIDTH_D,
  parameter int QDR_DATA_WIDTH = QDR_DATA_WIDTH_D,
  parameter int QDR_BW_WIDTH   = QDR_BW_WIDTH_D,
  parameter int FIFO_AWIDTH    = FIFO_AWIDTH_D,
  parameter int OUTST_WIDTH    = OUTST_WIDTH_D
) (
  input  logic                        qdr_clk,
  input  logic                        qdr_rst,
  input  logic [QDR_ADDR_WIDTH-1:0]   user_addr,
  input  logic                        user_wr_strb,
  input  logic [2*QDR_DATA_WIDTH-1:0] user_wr_data,
  input  logic [2*QDR_BW_WIDTH-1:0]   user_wr_be,
  input  logic                        user_rd_strb,
  output logic                        user_full,
  output logic [2*QDR_DATA_WIDTH-1:0] user_rd_data,
  output logic                        user_rd_dvld,
  output logic [31:0]                 slave_addr,
  output logic                        slave_wr_strb,
  output logic [2*QDR_DATA_WIDTH-1:0] slave_wr_data,
  output logic [2*QDR_BW_WIDTH-1:0]   slave_wr_be,
  output logic                        slave_rd_strb,
  input  logic                        slave_ack,
  input  logic [2*QDR_DATA_WIDTH-1:0] slave_rd_data,
  input  logic                        slave_rd_dvld,
  output logic                        overflow_err,
  output logic                        underflow_err,
  output logic [15:0]                 drop_cnt,
  output logic [OUTST_WIDTH-1:0]      outstanding
);

  localparam int DW2      = 2 * QDR_DATA_WIDTH;
  localparam int BW2      = 2 * QDR_BW_WIDTH;
  localparam int DATA_LSB = f_data_lsb(QDR_BW_WIDTH);
  localparam int RD_BIT   = f_rd_bit(QDR_DATA_WIDTH, QDR_BW_WIDTH);
  localparam int WR_BIT   = f_wr_bit(QDR_DATA_WIDTH, QDR_BW_WIDTH);
  localparam int ADDR_LSB = f_addr_lsb(QDR_DATA_WIDTH, QDR_BW_WIDTH);
  localparam int ENTRY_W  = f_entry_w(QDR_ADDR_WIDTH, QDR_DATA_WIDTH, QDR_BW_WIDTH);
  localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = '1;

  logic [ENTRY_W-1:0]        w_din;
  logic [ENTRY_W-1:0]        w_head;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_push_req;
  logic                      w_pop;
  logic                      w_rd_pop;
  logic [QDR_ADDR_WIDTH-1:0] w_head_addr;
  logic [DW2-1:0]            w_head_data;
  logic [BW2-1:0]            w_head_be;

  logic [QDR_ADDR_WIDTH-1:0] r_hold_addr;
  logic [DW2-1:0]            r_hold_data;
  logic [BW2-1:0]            r_hold_be;
  logic [OUTST_WIDTH-1:0]    r_outst;
  logic                      r_ovf;
  logic                      r_unf;
  logic [15:0]               r_drop;
  logic                      r_rd_dvld;
  logic [DW2-1:0]            r_rd_data;

  assign w_push_req = user_wr_strb | user_rd_strb;
  assign w_din      = {user_addr, user_wr_strb, user_rd_strb, user_wr_data, user_wr_be};
  assign w_pop      = ~w_empty & slave_ack;

  qdr_req_fifo #(
    .WIDTH  (ENTRY_W),
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .i_clk   (qdr_clk),
    .i_rst   (qdr_rst),
    .i_push  (w_push_req),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_head_addr = w_head[ADDR_LSB +: QDR_ADDR_WIDTH];
  assign w_head_data = w_head[DATA_LSB +: DW2];
  assign w_head_be   = w_head[BE_LSB +: BW2];
  assign w_rd_pop    = w_pop & w_head[RD_BIT];

  // Slave address/data/be keep showing the last head once the queue drains.
  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_hold_be   <= '0;
    end else if (!w_empty) begin
      r_hold_addr <= w_head_addr;
      r_hold_data <= w_head_data;
      r_hold_be   <= w_head_be;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      r_outst   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_drop    <= '0;
      r_rd_dvld <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_dvld <= slave_rd_dvld;
      r_rd_data <= slave_rd_data;
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      // A read issue and a read return in the same cycle cancel out.
      if (w_rd_pop && !slave_rd_dvld) begin
        if (r_outst == OUTST_MAX) r_ovf <= 1'b1;
        else r_outst <= r_outst + 1'b1;
      end else if (!w_rd_pop && slave_rd_dvld) begin
        if (r_outst == '0) r_unf <= 1'b1;
        else r_outst <= r_outst - 1'b1;
      end
    end
  end

  assign user_full     = w_full;
  assign user_rd_data  = r_rd_data;
  assign user_rd_dvld  = r_rd_dvld;
  assign slave_wr_strb = ~w_empty & w_head[WR_BIT];
  assign slave_rd_strb = ~w_empty & w_head[RD_BIT];
  assign slave_addr    = 32'(w_empty ? r_hold_addr : w_head_addr);
  assign slave_wr_data = w_empty ? r_hold_data : w_head_data;
  assign slave_wr_be   = w_empty ? r_hold_be : w_head_be;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
  assign drop_cnt      = r_drop;
  assign outstanding   = r_outst;

endmodule
